// File: rtl/priority_encoder.sv
// Registered 4-to-2 priority encoder (in[3] highest priority) with a built-in
// cross-check: the code is computed by a behavioural, a dataflow and a
// gate-level encoder in parallel. Any disagreement between them is flagged.
//
// Ports:
//   clk      - clock, rising edge
//   rst_n    - asynchronous active-low reset, clears all outputs immediately
//   in       - 4-bit request vector, sampled every rising edge
//   out      - index of the highest-priority set bit (registered, 1-cycle latency)
//   valid    - any bit of the sampled vector was set (registered)
//   mismatch - the three encoders disagreed on the sampled vector (registered)
//
// CHECK_EN = 0 removes the dataflow/gate-level copies and ties mismatch low.

module priority_encoder #(
  parameter bit CHECK_EN = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] in,
  output logic [1:0] out,
  output logic       valid,
  output logic       mismatch
);

  localparam int unsigned CODE_W = 2;

  logic [CODE_W-1:0] w_beh_code;
  logic              w_beh_valid;
  logic              w_mismatch;

  logic [CODE_W-1:0] r_out;
  logic              r_valid;
  logic              r_mismatch;

  // Behavioural encoder: priority casez, defaults first so no latch is inferred.
  always_comb begin
    w_beh_code  = CODE_W'(0);
    w_beh_valid = 1'b0;
    casez (in)
      4'b1???: begin w_beh_code = 2'b11; w_beh_valid = 1'b1; end
      4'b01??: begin w_beh_code = 2'b10; w_beh_valid = 1'b1; end
      4'b001?: begin w_beh_code = 2'b01; w_beh_valid = 1'b1; end
      4'b0001: begin w_beh_code = 2'b00; w_beh_valid = 1'b1; end
      default: begin w_beh_code = 2'b00; w_beh_valid = 1'b0; end
    endcase
  end

  generate
    if (CHECK_EN) begin : g_check
      logic [CODE_W-1:0] w_df_code;
      logic              w_df_valid;
      logic [CODE_W-1:0] w_gate_code;
      logic              w_gate_valid;
      logic              w_n_in2;
      logic              w_in1_only;

      // Dataflow encoder.
      assign w_df_code[1] = in[3] | in[2];
      assign w_df_code[0] = in[3] | (~in[2] & in[1]);
      assign w_df_valid   = |in;

      // Gate-level encoder, same equations from primitives.
      not u_not_in2  (w_n_in2, in[2]);
      and u_and_in1  (w_in1_only, w_n_in2, in[1]);
      or  u_or_code1 (w_gate_code[1], in[3], in[2]);
      or  u_or_code0 (w_gate_code[0], in[3], w_in1_only);
      or  u_or_valid (w_gate_valid, in[3], in[2], in[1], in[0]);

      // Flag when any {code,valid} tuple differs from the others.
      assign w_mismatch = ({w_beh_code, w_beh_valid} != {w_df_code, w_df_valid}) |
                          ({w_beh_code, w_beh_valid} != {w_gate_code, w_gate_valid});
    end else begin : g_no_check
      assign w_mismatch = 1'b0;
    end
  endgenerate

  // Output register; published code/valid come from the behavioural path.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out      <= CODE_W'(0);
      r_valid    <= 1'b0;
      r_mismatch <= 1'b0;
    end else begin
      r_out      <= w_beh_code;
      r_valid    <= w_beh_valid;
      r_mismatch <= w_mismatch;
    end
  end

  assign out      = r_out;
  assign valid    = r_valid;
  assign mismatch = r_mismatch;

endmodule

// File: tb/tb_priority_encoder.sv
// Bench for priority_encoder: one instance with the cross-check enabled and
// one with it removed, driven from the same stimulus.

module tb_priority_encoder;

  logic       clk;
  logic       rst_n;
  logic [3:0] in;
  logic [1:0] out1;
  logic       valid1;
  logic       mismatch1;
  logic [1:0] out0;
  logic       valid0;
  logic       mismatch0;

  int n_checks = 0;
  int n_errors = 0;

  typedef struct {
    logic [3:0] vin;
    logic [1:0] eout;
    logic       evalid;
  } vec_t;

  vec_t tbl [24];

  priority_encoder #(.CHECK_EN(1'b1)) u_dut_chk (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .out      (out1),
    .valid    (valid1),
    .mismatch (mismatch1)
  );

  priority_encoder #(.CHECK_EN(1'b0)) u_dut_nochk (
    .clk      (clk),
    .rst_n    (rst_n),
    .in       (in),
    .out      (out0),
    .valid    (valid0),
    .mismatch (mismatch0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Compare both instances against one expected {out,valid}; mismatch must be 0.
  task automatic chk_all(input string name, input logic [1:0] eo, input logic ev);
    chk({name, " chk out/valid"}, 8'({out1, valid1}), 8'({eo, ev}));
    chk({name, " chk mismatch"}, 8'(mismatch1), 8'd0);
    chk({name, " nochk out/valid"}, 8'({out0, valid0}), 8'({eo, ev}));
    chk({name, " nochk mismatch"}, 8'(mismatch0), 8'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0] prev_o;
    logic       prev_v;

    // One-hot sweep, multi-bit priority, then all 16 inputs.
    tbl[0]  = '{4'b0000, 2'b00, 1'b0};
    tbl[1]  = '{4'b0001, 2'b00, 1'b1};
    tbl[2]  = '{4'b0010, 2'b01, 1'b1};
    tbl[3]  = '{4'b0100, 2'b10, 1'b1};
    tbl[4]  = '{4'b1000, 2'b11, 1'b1};
    tbl[5]  = '{4'b0110, 2'b10, 1'b1};
    tbl[6]  = '{4'b1100, 2'b11, 1'b1};
    tbl[7]  = '{4'b1111, 2'b11, 1'b1};
    tbl[8]  = '{4'b0000, 2'b00, 1'b0};
    tbl[9]  = '{4'b0001, 2'b00, 1'b1};
    tbl[10] = '{4'b0010, 2'b01, 1'b1};
    tbl[11] = '{4'b0011, 2'b01, 1'b1};
    tbl[12] = '{4'b0100, 2'b10, 1'b1};
    tbl[13] = '{4'b0101, 2'b10, 1'b1};
    tbl[14] = '{4'b0110, 2'b10, 1'b1};
    tbl[15] = '{4'b0111, 2'b10, 1'b1};
    tbl[16] = '{4'b1000, 2'b11, 1'b1};
    tbl[17] = '{4'b1001, 2'b11, 1'b1};
    tbl[18] = '{4'b1010, 2'b11, 1'b1};
    tbl[19] = '{4'b1011, 2'b11, 1'b1};
    tbl[20] = '{4'b1100, 2'b11, 1'b1};
    tbl[21] = '{4'b1101, 2'b11, 1'b1};
    tbl[22] = '{4'b1110, 2'b11, 1'b1};
    tbl[23] = '{4'b1111, 2'b11, 1'b1};

    // Reset with all requests set: outputs clear with no clock edge.
    rst_n = 1'b0;
    in    = 4'b1111;
    #2;
    chk_all("reset_no_edge", 2'b00, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset_held", 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all("release_before_edge", 2'b00, 1'b0);
    @(posedge clk);
    #1;
    chk_all("first_after_release", 2'b11, 1'b1);

    // Table sweep: output holds the old value until the edge, then follows.
    prev_o = 2'b11;
    prev_v = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      in = tbl[i].vin;
      #1;
      chk_all($sformatf("hold_before_edge[%0d]", i), prev_o, prev_v);
      @(posedge clk);
      #1;
      chk_all($sformatf("vec[%0d]=%b", i, tbl[i].vin), tbl[i].eout, tbl[i].evalid);
      prev_o = tbl[i].eout;
      prev_v = tbl[i].evalid;
    end

    // Mid-stream asynchronous reset while out=11.
    @(negedge clk);
    in = 4'b1000;
    @(posedge clk);
    #1;
    chk_all("pre_midreset", 2'b11, 1'b1);
    #1;
    rst_n = 1'b0;
    #1;
    chk_all("midreset_immediate", 2'b00, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk_all("midreset_released_no_edge", 2'b00, 1'b0);
    @(posedge clk);
    #1;
    chk_all("midreset_recover", 2'b11, 1'b1);

    // Unknown input bit, then recovery on the next clean sample.
    @(negedge clk);
    in = 4'bx010;
    @(posedge clk);
    @(negedge clk);
    in = 4'b0010;
    @(posedge clk);
    #1;
    chk_all("x_recover", 2'b01, 1'b1);

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
